// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the ARM register-file write-port decoder.
//   RF_ADDR_W   : default register address width
//   RF_NUM_REGS : default number of decoded registers (2**RF_ADDR_W)
//   RF_PC_IDX   : register index treated as the program counter
//   rf_onehot_t : one-hot register enable vector at the default size
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;
  localparam int RF_PC_IDX   = 15;

  typedef logic [RF_NUM_REGS-1:0] rf_onehot_t;

endpackage : regfile_pkg

// File: rtl/regfile_onehot_dec.sv
// -----------------------------------------------------------------------------
// regfile_onehot_dec
// Purely combinational ADDR_W-to-NUM_REGS one-hot decoder with enable.
// Ports:
//   i_en     : decode enable; when low the output is all-zero
//   i_addr   : register address
//   o_onehot : one-hot register select (all-zero if disabled or the
//              address is not below NUM_REGS)
// -----------------------------------------------------------------------------
module regfile_onehot_dec
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);

  // Only indices that exist can match, so an address at or above NUM_REGS
  // naturally decodes to no enable at all.
  always_comb begin
    o_onehot = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (i_en && (i_addr == r[ADDR_W-1:0])) begin
        o_onehot[r] = 1'b1;
      end
    end
  end

endmodule : regfile_onehot_dec

// File: rtl/regfile_wr_decoder.sv
// -----------------------------------------------------------------------------
// regfile_wr_decoder
// Registered multi-port write decoder for the ARM register file. Each port's
// (ld, addr) request becomes a one-hot register enable one cycle later.
// Same-register requests are resolved by fixed priority (port 0 highest) and
// a per-register lock mask suppresses writes to locked registers.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ld           : per-port write request
//   addr         : port p address at [p*ADDR_W +: ADDR_W]
//   lock_set/clr : set / clear lock bit at lock_addr (set wins)
//   lock_addr    : lock target register
//   en           : port p one-hot enable at [p*NUM_REGS +: NUM_REGS]
//   en_any       : OR of all port enables
//   pc_wr        : a granted write targets PC_IDX
//   conflict     : a request lost to a higher-priority port on address match
//   blocked      : a request hit a locked register
//   conflict_cnt : saturating count of conflict cycles
//   lock_mask    : current lock mask
// All outputs are registers; there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module regfile_wr_decoder
  import regfile_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int NUM_REGS  = 2 ** ADDR_W,
  parameter int PC_IDX    = RF_PC_IDX,
  parameter int CNT_W     = 8,
  parameter logic [NUM_REGS-1:0] LOCK_RST = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          ld,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic                          lock_set,
  input  logic                          lock_clr,
  input  logic [ADDR_W-1:0]             lock_addr,
  output logic [NUM_PORTS*NUM_REGS-1:0] en,
  output logic [NUM_REGS-1:0]           en_any,
  output logic                          pc_wr,
  output logic                          conflict,
  output logic                          blocked,
  output logic [CNT_W-1:0]              conflict_cnt,
  output logic [NUM_REGS-1:0]           lock_mask
);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS*NUM_REGS-1:0] r_en;
  logic [NUM_REGS-1:0]           r_en_any;
  logic                          r_pc_wr;
  logic                          r_conflict;
  logic                          r_blocked;
  logic [CNT_W-1:0]              r_conflict_cnt;
  logic [NUM_REGS-1:0]           r_lock_mask;

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]  w_addr [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_req;     // ld with an address that exists
  logic [NUM_PORTS-1:0] w_shadow;  // a higher-priority port requests same reg
  logic [NUM_PORTS-1:0] w_locked;  // request targets a locked register
  logic [NUM_PORTS-1:0] w_grant;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_addr[p] = addr[p*ADDR_W +: ADDR_W];
      w_req[p]  = ld[p] && (int'(w_addr[p]) < NUM_REGS);
    end
  end

  // Priority is decided on requests, not grants: a higher-priority port that
  // is itself locked out still shadows lower-priority ports on the same
  // register. The lock check uses the mask as it stood before this edge.
  always_comb begin
    w_shadow = '0;
    w_locked = '0;
    w_grant  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (w_req[q] && (w_addr[q] == w_addr[p])) begin
          w_shadow[p] = 1'b1;
        end
      end
      if (w_req[p] && r_lock_mask[w_addr[p]]) begin
        w_locked[p] = 1'b1;
      end
      w_grant[p] = w_req[p] && !w_shadow[p] && !w_locked[p];
    end
  end

  logic w_conflict;
  logic w_blocked;

  assign w_conflict = |(w_req & w_shadow);
  assign w_blocked  = |w_locked;

  // ---------------------------------------------------------------------------
  // Per-port one-hot decode of granted requests
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS*NUM_REGS-1:0] w_en;
  logic [NUM_REGS-1:0]           w_en_any;

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_dec
    regfile_onehot_dec #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
    ) u_dec (
      .i_en     (w_grant[gp]),
      .i_addr   (w_addr[gp]),
      .o_onehot (w_en[gp*NUM_REGS +: NUM_REGS])
    );
  end

  always_comb begin
    w_en_any = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_en_any = w_en_any | w_en[p*NUM_REGS +: NUM_REGS];
    end
  end

  // A PC index outside the decoded range can never be written.
  logic w_pc_wr;
  if (PC_IDX < NUM_REGS) begin : g_pc
    assign w_pc_wr = w_en_any[PC_IDX];
  end else begin : g_no_pc
    assign w_pc_wr = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Lock mask next state: set beats clear; out-of-range targets are ignored.
  // ---------------------------------------------------------------------------
  logic                w_lock_in_range;
  logic [NUM_REGS-1:0] w_lock_next;

  assign w_lock_in_range = int'(lock_addr) < NUM_REGS;

  always_comb begin
    w_lock_next = r_lock_mask;
    if (w_lock_in_range) begin
      if (lock_set) begin
        w_lock_next[lock_addr] = 1'b1;
      end else if (lock_clr) begin
        w_lock_next[lock_addr] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output and state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en           <= '0;
      r_en_any       <= '0;
      r_pc_wr        <= 1'b0;
      r_conflict     <= 1'b0;
      r_blocked      <= 1'b0;
      r_conflict_cnt <= '0;
      r_lock_mask    <= LOCK_RST;
    end else begin
      r_en        <= w_en;
      r_en_any    <= w_en_any;
      r_pc_wr     <= w_pc_wr;
      r_conflict  <= w_conflict;
      r_blocked   <= w_blocked;
      r_lock_mask <= w_lock_next;
      // One increment per conflict cycle, holding at all-ones.
      if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
    end
  end

  assign en           = r_en;
  assign en_any       = r_en_any;
  assign pc_wr        = r_pc_wr;
  assign conflict     = r_conflict;
  assign blocked      = r_blocked;
  assign conflict_cnt = r_conflict_cnt;
  assign lock_mask    = r_lock_mask;

endmodule : regfile_wr_decoder

// File: tb/tb_regfile_wr_decoder.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_decoder
// Directed and randomized stimulus for regfile_wr_decoder at default
// parameters (2 ports, 16 registers, PC at 15, 8-bit counter), compared with
// a request-level reference model.
// -----------------------------------------------------------------------------
module tb_regfile_wr_decoder;
  import regfile_pkg::*;

  localparam int NP = 2;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int CW = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NP-1:0]    ld;
  logic [NP*AW-1:0] addr;
  logic             lock_set;
  logic             lock_clr;
  logic [AW-1:0]    lock_addr;
  logic [NP*NR-1:0] en;
  logic [NR-1:0]    en_any;
  logic             pc_wr;
  logic             conflict;
  logic             blocked;
  logic [CW-1:0]    conflict_cnt;
  logic [NR-1:0]    lock_mask;

  regfile_wr_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld           (ld),
    .addr         (addr),
    .lock_set     (lock_set),
    .lock_clr     (lock_clr),
    .lock_addr    (lock_addr),
    .en           (en),
    .en_any       (en_any),
    .pc_wr        (pc_wr),
    .conflict     (conflict),
    .blocked      (blocked),
    .conflict_cnt (conflict_cnt),
    .lock_mask    (lock_mask)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: register-level view of the decoder rules
  // ---------------------------------------------------------------------------
  bit [NR-1:0]    m_lock;
  int             m_cnt;
  logic [NP*NR-1:0] exp_en;
  logic [NR-1:0]  exp_any;
  logic           exp_pc;
  logic           exp_conf;
  logic           exp_blk;

  task automatic model_step(input logic [NP-1:0] l, input int a [NP],
                            input logic ls, input logic lc, input int la);
    exp_en   = '0;
    exp_conf = 1'b0;
    exp_blk  = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (l[p]) begin
        bit lost;
        lost = 1'b0;
        for (int q = 0; q < p; q++)
          if (l[q] && a[q] == a[p]) lost = 1'b1;
        if (lost) exp_conf = 1'b1;
        if (m_lock[a[p]]) exp_blk = 1'b1;
        if (!lost && !m_lock[a[p]]) exp_en[p*NR + a[p]] = 1'b1;
      end
    end
    exp_any = '0;
    for (int p = 0; p < NP; p++) exp_any |= exp_en[p*NR +: NR];
    exp_pc = exp_any[RF_PC_IDX];
    if (exp_conf && m_cnt < (1 << CW) - 1) m_cnt++;
    if (ls) m_lock[la] = 1'b1;
    else if (lc) m_lock[la] = 1'b0;
  endtask

  task automatic model_reset();
    m_lock = '0;
    m_cnt  = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock of stimulus, then compare every output with the model
  // ---------------------------------------------------------------------------
  task automatic do_cycle(input string tag, input logic [1:0] l,
                          input int a0, input int a1,
                          input logic ls, input logic lc, input int la);
    int a [NP];
    a[0] = a0;
    a[1] = a1;
    @(negedge clk);
    ld        = l;
    addr      = {a1[AW-1:0], a0[AW-1:0]};
    lock_set  = ls;
    lock_clr  = lc;
    lock_addr = la[AW-1:0];
    model_step(l, a, ls, lc, la);
    @(posedge clk);
    #1;
    check_eq({tag, ".en"},       32'(en),           32'(exp_en));
    check_eq({tag, ".en_any"},   32'(en_any),       32'(exp_any));
    check_eq({tag, ".pc_wr"},    32'(pc_wr),        32'(exp_pc));
    check_eq({tag, ".conflict"}, 32'(conflict),     32'(exp_conf));
    check_eq({tag, ".blocked"},  32'(blocked),      32'(exp_blk));
    check_eq({tag, ".cnt"},      32'(conflict_cnt), 32'(m_cnt));
    check_eq({tag, ".lock"},     32'(lock_mask),    32'(m_lock));
  endtask

  task automatic check_all_clear(input string tag);
    check_eq({tag, ".en"},       32'(en),           32'h0);
    check_eq({tag, ".en_any"},   32'(en_any),       32'h0);
    check_eq({tag, ".pc_wr"},    32'(pc_wr),        32'h0);
    check_eq({tag, ".conflict"}, 32'(conflict),     32'h0);
    check_eq({tag, ".blocked"},  32'(blocked),      32'h0);
    check_eq({tag, ".cnt"},      32'(conflict_cnt), 32'h0);
    check_eq({tag, ".lock"},     32'(lock_mask),    32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rf_onehot_t one_hot;
    rst_n     = 1'b0;
    ld        = '0;
    addr      = '0;
    lock_set  = 1'b0;
    lock_clr  = 1'b0;
    lock_addr = '0;
    model_reset();

    // Reset held for two cycles, then idle.
    repeat (2) @(posedge clk);
    #1;
    check_all_clear("reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle("idle", 2'b00, 0, 0, 1'b0, 1'b0, 0);
    check_all_clear("idle_clear");

    // Single port decode, then an address sweep with PC at 15.
    do_cycle("single3", 2'b01, 3, 0, 1'b0, 1'b0, 0);
    check_eq("single3.en_any_k", 32'(en_any), 32'h0008);
    for (int i = 0; i < NR; i++) begin
      do_cycle("sweep", 2'b01, i, 0, 1'b0, 1'b0, 0);
      one_hot = '0;
      one_hot[i] = 1'b1;
      check_eq("sweep.walk", 32'(en_any), 32'(one_hot));
      check_eq("sweep.pc", 32'(pc_wr), (i == 15) ? 32'h1 : 32'h0);
    end
    do_cycle("pulse", 2'b00, 15, 0, 1'b0, 1'b0, 0);
    check_eq("pulse.en_any_k", 32'(en_any), 32'h0);

    // Two ports: distinct registers, then the same register.
    do_cycle("dual_dist", 2'b11, 2, 5, 1'b0, 1'b0, 0);
    check_eq("dual_dist.en_any_k", 32'(en_any), 32'h0024);
    do_cycle("dual_same", 2'b11, 7, 7, 1'b0, 1'b0, 0);
    check_eq("dual_same.en_k", 32'(en), 32'h0000_0080);
    check_eq("dual_same.conf_k", 32'(conflict), 32'h1);
    check_eq("dual_same.cnt_k", 32'(conflict_cnt), 32'h1);
    do_cycle("port1_only", 2'b10, 0, 15, 1'b0, 1'b0, 0);
    check_eq("port1_only.en_k", 32'(en), 32'h8000_0000);

    // Lock mask behaviour around register 4.
    do_cycle("lock4", 2'b00, 0, 0, 1'b1, 1'b0, 4);
    check_eq("lock4.mask_k", 32'(lock_mask), 32'h0010);
    do_cycle("wr4_locked", 2'b01, 4, 0, 1'b0, 1'b0, 0);
    check_eq("wr4_locked.blk_k", 32'(blocked), 32'h1);
    do_cycle("wr4_clr", 2'b01, 4, 0, 1'b0, 1'b1, 4);
    check_eq("wr4_clr.blk_k", 32'(blocked), 32'h1);
    do_cycle("wr4_free", 2'b01, 4, 0, 1'b0, 1'b0, 0);
    check_eq("wr4_free.en_any_k", 32'(en_any), 32'h0010);

    // Locked higher-priority port still shadows the lower port.
    do_cycle("lock6", 2'b00, 0, 0, 1'b1, 1'b0, 6);
    do_cycle("shadow6", 2'b11, 6, 6, 1'b0, 1'b0, 0);
    check_eq("shadow6.en_k", 32'(en), 32'h0);
    check_eq("shadow6.conf_k", 32'(conflict), 32'h1);
    check_eq("shadow6.blk_k", 32'(blocked), 32'h1);
    do_cycle("unlock6", 2'b00, 0, 0, 1'b0, 1'b1, 6);

    // Set and clear together: set wins. Same-cycle write and lock.
    do_cycle("setclr9", 2'b00, 0, 0, 1'b1, 1'b1, 9);
    check_eq("setclr9.mask_k", 32'(lock_mask), 32'h0200);
    do_cycle("wr1_lock1", 2'b01, 1, 0, 1'b1, 1'b0, 1);
    check_eq("wr1_lock1.en_any_k", 32'(en_any), 32'h0002);
    do_cycle("wr1_after", 2'b01, 1, 0, 1'b0, 1'b0, 0);
    check_eq("wr1_after.blk_k", 32'(blocked), 32'h1);

    // Counter saturation at 2**CW-1 after a long run of conflicts.
    for (int i = 0; i < 260; i++)
      do_cycle("sat", 2'b11, i % 16 == 1 ? 3 : i % 16, i % 16 == 1 ? 3 : i % 16,
               1'b0, 1'b0, 0);
    check_eq("sat.cnt_k", 32'(conflict_cnt), 32'hFF);

    // Asynchronous reset between clock edges.
    do_cycle("pre_arst", 2'b01, 3, 0, 1'b0, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_clear("arst");
    ld = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle("post_arst", 2'b00, 0, 0, 1'b0, 1'b0, 0);

    // Randomized traffic with frequent address collisions and lock churn.
    for (int i = 0; i < 400; i++) begin
      int a0, a1, la;
      logic [1:0] l;
      logic ls, lc;
      l  = 2'($urandom_range(0, 3));
      a0 = $urandom_range(0, 15);
      a1 = ($urandom_range(0, 2) == 0) ? a0 : $urandom_range(0, 15);
      ls = ($urandom_range(0, 5) == 0);
      lc = ($urandom_range(0, 3) == 0);
      la = ($urandom_range(0, 1) == 0) ? a0 : $urandom_range(0, 15);
      do_cycle("rand", l, a0, a1, ls, lc, la);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_regfile_wr_decoder

// File: doc/regfile_wr_decoder.md
Name: regfile_wr_decoder

Overview:
- Parametrised, registered write-port decoder for the ARM register file; successor to the single-port 4-to-16 load decoder.
- Decodes NUM_PORTS independent (ld, addr) write requests into one-hot per-register enables with one cycle of latency.
- Resolves same-register conflicts between ports by fixed priority and enforces a per-register write-lock mask.
- Flags PC writes and counts conflicts; sits between the writeback stage and the register array.

Parameters:
- NUM_PORTS, 2, number of write ports (1..4); port 0 has the highest priority.
- ADDR_W, 4, register address width.
- NUM_REGS, 2**ADDR_W, number of registers decoded (16).
- PC_IDX, 15, register index treated as the PC.
- CNT_W, 8, conflict counter width.
- LOCK_RST, {NUM_REGS{1'b0}}, lock mask value after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld  in  NUM_PORTS  per-port write request.
- addr  in  NUM_PORTS*ADDR_W  port p address at [p*ADDR_W +: ADDR_W].
- lock_set  in  1  set the lock bit at lock_addr.
- lock_clr  in  1  clear the lock bit at lock_addr.
- lock_addr  in  ADDR_W  lock target.
- en  out  NUM_PORTS*NUM_REGS  port p one-hot enable at [p*NUM_REGS +: NUM_REGS].
- en_any  out  NUM_REGS  OR of all port enables.
- pc_wr  out  1  a granted write targets PC_IDX.
- conflict  out  1  at least one request was suppressed by a higher-priority port.
- blocked  out  1  at least one request was suppressed by the lock mask.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.
- lock_mask  out  NUM_REGS  current lock mask.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n).
- Reset (rst_n low, immediate, independent of clk):
  - en, en_any, pc_wr, conflict, blocked, conflict_cnt cleared to 0.
  - lock_mask set to LOCK_RST.
- Latency: requests sampled at edge t produce outputs visible after edge t; every output is a register. With no requests, all enables are 0 the following cycle (pulse outputs, no hold).
- Grant rule for port p, evaluated against the lock_mask value before this edge's update:
  - ld[p] must be 1, and lock_mask[addr[p]] must be 0.
  - No port q<p may have ld[q]=1 and addr[q]=addr[p].
  - Priority compares requests, not grants: a locked lower port still shadows a higher port with the same address.
- en for port p: one-hot at addr[p] if granted, all-zero otherwise. Invariant: en_any has at most one granted port per bit.
- conflict = 1 if any port with ld=1 lost on address match.
- blocked = 1 if any port with ld=1 hit a locked register. Both flags can be 1 in the same cycle.
- pc_wr = en_any[PC_IDX].
- conflict_cnt increments by 1 per conflict cycle (not per suppressed port) and saturates at 2**CNT_W-1; no wrap.
- Lock update at the edge:
  - lock_set=1 sets bit lock_addr; lock_clr=1 clears it.
  - If both are asserted, set wins.
  - The new mask affects grants from the next cycle only; a write and a lock to the same register in one cycle leaves the write granted.
- An out-of-range address is impossible because NUM_REGS=2**ADDR_W. If NUM_REGS is overridden lower, addr >= NUM_REGS is ignored: no enable, no flag.
- Reset asserted mid-operation clears in-flight enables; nothing carries over after rst_n rises.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package regfile_pkg: ADDR_W, NUM_REGS, PC_IDX, and a typedef for a register one-hot vector.
- One sub-module, regfile_onehot_dec: purely combinational, ADDR_W-to-NUM_REGS one-hot with an enable input. Instantiated NUM_PORTS times; the top level holds the priority logic, lock mask, counter and output registers.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then ld=0 -> all outputs 0, lock_mask=0, conflict_cnt=0. Assert rst_n asynchronously mid-cycle -> outputs clear without waiting for a clk edge.
- Single port decode: ld=2'b01, addr0=4'd3 -> next cycle en[3]=1 for port 0, en_any=16'h0008, pc_wr=0. Sweep addr0 0..15 -> en_any walks 0x0001..0x8000, and pc_wr=1 only at 15.
- Dual port distinct vs. same address:
  - ld=2'b11, addr0=2, addr1=5 -> en_any=16'h0024, conflict=0.
  - addr0=addr1=7 -> only port 0 bit 7 set, port 1 enables all 0, conflict=1, conflict_cnt increments by 1.
- Lock mask: lock_set, lock_addr=4 -> lock_mask=16'h0010.
  - Next cycle ld=2'b01, addr0=4 -> en all 0, blocked=1.
  - lock_clr plus write to 4 in the same cycle -> still blocked.
  - Following write to 4 -> granted.
- Lock set/clear collision and same-cycle lock: lock_set=lock_clr=1, lock_addr=9 -> bit 9 set. Write plus lock_set to register 1 in the same cycle -> write granted, lock applies next cycle.
- Counter saturation, CNT_W=2: 5 consecutive conflict cycles -> conflict_cnt goes 1,2,3,3,3.
